// File: rtl/demux_ctrl_pkg.sv
// Shared constants and types for the byte-to-word demux controller.
// Lane count and lane-index width are tied together: LANES = 4 needs a 2-bit index.
package demux_ctrl_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 3;

    typedef logic [1:0]       lane_idx_t;
    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StHold
    } state_t;

endpackage

// File: rtl/lane_demux.sv
// Steers one byte into its lane of an otherwise-zero word; lane 0 is the MSB lane.
module lane_demux
    import demux_ctrl_pkg::*;
#(
    parameter int unsigned LaneW = LANE_W,
    parameter int unsigned Lanes = LANES
) (
    input  logic [LaneW-1:0]       data_i,
    input  lane_idx_t              sel_i,
    output logic [Lanes*LaneW-1:0] lanes_o
);

    always_comb begin
        lanes_o = '0;
        for (int k = 0; k < Lanes; k++) begin
            if (sel_i == lane_idx_t'(k)) begin
                lanes_o[(Lanes - k) * LaneW - 1 -: LaneW] = data_i;
            end
        end
    end

endmodule

// File: rtl/demux_word_ctrl.sv
// Packs a byte stream into MSB-first words of LANES bytes, with flush of partial words
// and a single holding slot whose ready passes straight through for gapless streaming.
module demux_word_ctrl #(
    parameter int unsigned LANE_W = demux_ctrl_pkg::LANE_W,
    parameter int unsigned LANES  = demux_ctrl_pkg::LANES
) (
    input  logic                       inClk,
    input  logic                       inRst,
    input  logic [LANE_W-1:0]          inData,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic                       inFlush,
    output demux_ctrl_pkg::lane_idx_t  outSel,
    output logic [LANES*LANE_W-1:0]    outData,
    output demux_ctrl_pkg::count_t     outCount,
    output logic                       outValid,
    input  logic                       outReady
);

    localparam demux_ctrl_pkg::lane_idx_t LastLane = demux_ctrl_pkg::lane_idx_t'(LANES - 1);

    demux_ctrl_pkg::state_t    state_q, state_d;
    demux_ctrl_pkg::lane_idx_t cnt_q, cnt_d;
    demux_ctrl_pkg::count_t    count_q, count_d;
    logic [LANES*LANE_W-1:0]   word_q, word_d;
    logic [LANES*LANE_W-1:0]   lane_word;
    logic                      byte_acc;
    logic                      word_acc;

    lane_demux #(
        .LaneW (LANE_W),
        .Lanes (LANES)
    ) u_lane_demux (
        .data_i  (inData),
        .sel_i   (cnt_q),
        .lanes_o (lane_word)
    );

    assign outSel   = cnt_q;
    assign outData  = word_q;
    assign outCount = count_q;
    assign outValid = (state_q == demux_ctrl_pkg::StHold);

    always_comb begin
        inReady  = !inRst && ((state_q != demux_ctrl_pkg::StHold) || outReady);
        byte_acc = inValid && inReady;
        word_acc = outValid && outReady;

        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        word_d  = word_q;

        unique case (state_q)
            demux_ctrl_pkg::StIdle: begin
                if (byte_acc) begin
                    word_d  = lane_word;
                    count_d = demux_ctrl_pkg::count_t'(1);
                    if (inFlush) begin
                        state_d = demux_ctrl_pkg::StHold;
                        cnt_d   = '0;
                    end else begin
                        state_d = demux_ctrl_pkg::StFill;
                        cnt_d   = 2'd1;
                    end
                end
            end
            demux_ctrl_pkg::StFill: begin
                if (byte_acc) begin
                    word_d  = word_q | lane_word;
                    count_d = count_q + demux_ctrl_pkg::count_t'(1);
                    if (cnt_q == LastLane || inFlush) begin
                        state_d = demux_ctrl_pkg::StHold;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (inFlush && cnt_q != '0) begin
                    state_d = demux_ctrl_pkg::StHold;
                    cnt_d   = '0;
                end
            end
            demux_ctrl_pkg::StHold: begin
                if (word_acc) begin
                    if (byte_acc) begin
                        // Counter is already 0 here, so the byte lands in lane 0 of a fresh word.
                        word_d  = lane_word;
                        count_d = demux_ctrl_pkg::count_t'(1);
                        if (inFlush) begin
                            state_d = demux_ctrl_pkg::StHold;
                            cnt_d   = '0;
                        end else begin
                            state_d = demux_ctrl_pkg::StFill;
                            cnt_d   = 2'd1;
                        end
                    end else begin
                        state_d = demux_ctrl_pkg::StIdle;
                        cnt_d   = '0;
                        count_d = '0;
                        word_d  = '0;
                    end
                end
            end
            default: begin
                state_d = demux_ctrl_pkg::StIdle;
                cnt_d   = '0;
                count_d = '0;
                word_d  = '0;
            end
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q <= demux_ctrl_pkg::StIdle;
            cnt_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_demux_word_ctrl.sv
// Scoreboard bench: byte-level reference model predicts words, a negedge monitor checks them.
module tb_demux_word_ctrl;

    logic       clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_flush = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sel;
    logic [31:0] out_data;
    logic [2:0] out_count;

    int tests = 0;
    int fails = 0;

    bit checks_on = 1'b0;
    bit rst_prev  = 1'b0;
    bit pending   = 1'b0;

    logic [7:0]  partial[$];
    logic [31:0] exp_data[$];
    int          exp_cnt[$];

    always #5 clk = ~clk;

    demux_word_ctrl dut (
        .inClk    (clk),
        .inRst    (in_rst),
        .inData   (in_data),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inFlush  (in_flush),
        .outSel   (out_sel),
        .outData  (out_data),
        .outCount (out_count),
        .outValid (out_valid),
        .outReady (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes fill from the most significant lane down; unfilled lanes stay zero.
    task automatic complete_word();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < partial.size(); i++) begin
            w = w | (32'(partial[i]) << (8 * (3 - i)));
        end
        exp_data.push_back(w);
        exp_cnt.push_back(partial.size());
        partial.delete();
        pending = 1'b1;
    endtask

    // Compares the current cycle's handshake outputs, then predicts the next clock edge.
    task automatic model_step();
        bit exp_ready;
        bit consumed;
        bit accepted;
        exp_ready = !in_rst && (!pending || out_ready);
        if (checks_on) begin
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(pending));
            check("out_sel", 32'(out_sel), 32'(partial.size()));
            if (rst_prev) begin
                check("rst_data", out_data, 32'h0);
                check("rst_count", 32'(out_count), 32'h0);
            end
        end
        if (in_rst) begin
            partial.delete();
            exp_data.delete();
            exp_cnt.delete();
            pending   = 1'b0;
            checks_on = 1'b1;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            consumed = pending && out_ready;
            accepted = in_valid && exp_ready;
            if (consumed) pending = 1'b0;
            if (accepted) begin
                partial.push_back(in_data);
                if (partial.size() == 4 || in_flush) complete_word();
            end else if (in_flush && partial.size() != 0) begin
                complete_word();
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic r,
                       input logic rst);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_flush  = f;
        out_ready = r;
        in_rst    = rst;
        #1;
        model_step();
    endtask

    // Monitor: every word transfer must match the oldest predicted word, and a stalled
    // word must not change until it is taken.
    initial begin
        bit          stall_prev;
        logic [31:0] hold_data;
        logic [2:0]  hold_cnt;
        stall_prev = 1'b0;
        hold_data  = 32'h0;
        hold_cnt   = 3'h0;
        forever begin
            @(negedge clk);
            if (checks_on && !in_rst) begin
                if (stall_prev) begin
                    check("hold_valid", 32'(out_valid), 32'h1);
                    check("hold_data", out_data, hold_data);
                    check("hold_count", 32'(out_count), 32'(hold_cnt));
                end
                if (out_valid && out_ready) begin
                    if (exp_data.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                    end else begin
                        check("word_data", out_data, exp_data.pop_front());
                        check("word_count", 32'(out_count), 32'(exp_cnt.pop_front()));
                    end
                end
                stall_prev = out_valid && !out_ready;
                hold_data  = out_data;
                hold_cnt   = out_count;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] seq4[4];

        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 1, 0);

        // Full word streaming.
        seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq4[i]) cyc(1, seq4[i], 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Back-pressure, then zero-bubble handoff into the next word.
        foreach (seq4[i]) cyc(1, seq4[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'hAA, 0, 0, 0);
        cyc(1, 8'hAA, 0, 1, 0);
        cyc(1, 8'hBB, 0, 1, 0);
        cyc(1, 8'hCC, 0, 1, 0);
        cyc(1, 8'hDD, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Flush with the second byte.
        cyc(1, 8'h5A, 0, 1, 0);
        cyc(1, 8'hC3, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Flush with nothing buffered must not produce a word.
        cyc(0, 8'h00, 1, 1, 0);
        cyc(0, 8'h00, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Reset mid-word, then a clean word.
        cyc(1, 8'hE1, 0, 1, 0);
        cyc(1, 8'hE2, 0, 1, 0);
        cyc(1, 8'hE3, 0, 1, 0);
        cyc(1, 8'hE4, 1, 1, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Continuous streaming, 16 bytes.
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
        end

        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 0, 1, 0);
        check("scoreboard_empty", 32'(exp_data.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_word_ctrl.md
DEMUX_WORD_CTRL -- requirements
Module: demux_word_ctrl

Interface
REQ-001 SHALL have parameter LANE_W, default 8, meaning bits per lane (byte).
REQ-002 SHALL have parameter LANES, default 4, meaning lanes per output word; the output word width is LANES*LANE_W (32).
REQ-003 SHALL have port inClk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port inRst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port inData, input, LANE_W, the incoming byte.
REQ-006 SHALL have port inValid, input, 1, meaning inData is valid this cycle.
REQ-007 SHALL have port inReady, output, 1, meaning the block accepts inData this cycle.
REQ-008 SHALL have port inFlush, input, 1, meaning emit the partial word now; it is sampled only with an accepted byte or in FILL.
REQ-009 SHALL have port outSel, output, 2, the lane index the next accepted byte is routed to (demux select).
REQ-010 SHALL have port outData, output, 32, the assembled word.
REQ-011 SHALL have port outCount, output, 3, the number of valid lanes in outData (1..4).
REQ-012 SHALL have port outValid, output, 1, meaning outData/outCount are valid.
REQ-013 SHALL have port outReady, input, 1, meaning the downstream consumes the word.

Function
REQ-014 SHALL implement FSM states IDLE, FILL and HOLD.
REQ-015 Byte transfer SHALL occur when inValid&&inReady; word transfer SHALL occur when outValid&&outReady.
REQ-016 The lane counter SHALL start at 0 and increment by 1 per accepted byte; outSel SHALL equal the counter.
REQ-017 Lane k SHALL map to outData[31-8k -: 8]: the first byte goes to the MSB lane and the fourth to [7:0].
REQ-018 Lanes not yet written in the current word SHALL read 0.
REQ-019 Transitions SHALL be:
- IDLE -> FILL on an accepted byte.
- FILL -> HOLD on acceptance of the lane-3 byte, or on an accepted byte with inFlush=1.
- FILL -> HOLD on inFlush=1 with no byte while counter>0.
- HOLD -> IDLE on a word transfer with no simultaneous byte.
- HOLD -> FILL on a word transfer with a simultaneous byte.
REQ-020 inReady SHALL be 1 in IDLE and FILL; in HOLD it SHALL equal outReady, a combinational pass-through for zero-bubble streaming.
REQ-021 Latency SHALL be: outValid asserts in the cycle after the completing byte is accepted.
- Sustained throughput is 1 byte/cycle.
- Back-to-back 4-byte words emit one word every 4 cycles with no bubble.
REQ-022 On a simultaneous word transfer and byte acceptance in HOLD, the new byte SHALL go to lane 0 of a cleared word and the counter SHALL become 1.
REQ-023 outValid, outData and outCount SHALL be held stable while outValid=1 and outReady=0.
REQ-024 outCount SHALL equal the number of bytes accepted into the word (4 on wrap, 1..3 on flush).
REQ-025 The counter SHALL wrap 3 -> 0 on entry to HOLD.
REQ-026 inFlush in IDLE with no byte SHALL be ignored; no empty word is ever emitted.
REQ-027 outValid SHALL be 0 in IDLE and FILL, and 1 in HOLD.

Reset
REQ-028 inRst=1 SHALL, at the next inClk edge, force:
- state = IDLE;
- counter = 0, outSel = 0;
- outData = 0, outCount = 0, outValid = 0.
REQ-029 While inRst=1, inReady SHALL be 0.
REQ-030 Reset during FILL or HOLD SHALL discard the partial or pending word without emitting it.
REQ-031 Inputs during the reset cycle SHALL be ignored.

Structure
REQ-032 Package demux_ctrl_pkg SHALL hold:
- LANE_W and LANES constants;
- the state enum (IDLE/FILL/HOLD);
- the lane-index typedef (2 bits).
REQ-033 The byte-to-lane steering SHALL be one sub-module, lane_demux (1 byte in, outSel in, 32-bit one-lane-hot out), OR-merged into the word register by the controller.
REQ-034 All registers SHALL be in a single always_ff block, with next-state and handshake logic in always_comb.

Verification
REQ-035 The bench SHALL cover full-word streaming: bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles with outReady=1 -> outData=0x11223344, outCount=4, outValid=1 for one cycle, in the cycle after 0x44.
REQ-036 The bench SHALL cover back-pressure: after a full word with outReady=0 for 3 cycles -> inReady=0 and outData held at 0x11223344; on outReady=1 with inValid=1 (0xAA) -> word consumed and the next word starts with lane 0 = 0xAA.
REQ-037 The bench SHALL cover flush: bytes 0x5A,0xC3, with inFlush=1 on the 0xC3 transfer -> outData=0x5AC30000, outCount=2.
REQ-038 The bench SHALL cover idle flush: inFlush=1 with no bytes in IDLE -> outValid stays 0 and the state stays IDLE.
REQ-039 The bench SHALL cover reset mid-word: 3 bytes accepted, then inRst=1 for one cycle -> all outputs 0; the next 4 bytes 0x01..0x04 produce 0x01020304 with no residue.
REQ-040 The bench SHALL cover continuous streaming: 16 bytes with inValid=1 and outReady=1 -> 4 words, each 4 cycles apart, inReady never 0.
